// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0, x0, 0

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  // Width needed to hold a count in the range 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, instr} with push, pop, flush and occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                push_i,
  input  logic                                pop_i,
  input  logic                                flush_i,
  input  fetch_entry_t                        wdata_i,
  output fetch_entry_t                        rdata_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_entry_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;

  // Credits account for every outstanding request, so a push into a full,
  // non-popping buffer means the credit logic upstream is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push_i && !pop_i && !flush_i && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch front end: owns the PC, issues in-order credit-limited requests to
// instruction memory, buffers responses and presents the F-stage triple.
// Redirects flush the buffer and squash responses to wrong-path requests.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = FETCH_XLEN,  // must match fetch_entry_t.pc
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stallF,
  input  logic            redirectE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            validF,
  output logic [31:0]     instrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credits_used;
  logic            req_hs;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            fifo_pop;
  fetch_entry_t    fifo_wdata;
  fetch_entry_t    fifo_head;
  logic [XLEN-1:0] target_aligned;

  assign target_aligned = {PCTargetE[XLEN-1:2], 2'b00};

  // Credits are taken from registered counts only so the request never
  // combinationally depends on the response or ready inputs.
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = reset_n & ~redirectE & (credits_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr      = pc_q;

  assign req_hs   = imem_req_valid & imem_req_ready;
  assign rsp_drop = imem_rsp_valid & (drop_q != '0);
  assign rsp_keep = imem_rsp_valid & (drop_q == '0) & ~redirectE;
  assign fifo_pop = validF & ~stallF & ~redirectE;

  assign fifo_wdata = '{pc: rsp_pc_q, instr: imem_rsp_data};

  // PC, credit and squash-count next-state; a redirect overrides everything.
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirectE) begin
      pc_d          = target_aligned;
      rsp_pc_d      = target_aligned;
      // Any response arriving now is wrong-path too and is consumed here.
      outstanding_d = outstanding_q - CW'(imem_rsp_valid);
      drop_d        = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_hs)   pc_d     = pc_q + XLEN'(4);
      if (rsp_keep) rsp_pc_d = rsp_pc_q + XLEN'(4);
      if (rsp_drop) drop_d   = drop_q - CW'(1);
      outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (rsp_keep),
    .pop_i   (fifo_pop),
    .flush_i (redirectE),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .count_o (fifo_count)
  );

  // F-stage triple comes straight from the registered buffer head.
  assign validF   = (fifo_count != '0);
  assign instrF   = validF ? fifo_head.instr : NOP_INSTR;
  assign PCF      = validF ? fifo_head.pc : '0;
  assign PCPlus4F = validF ? (fifo_head.pc + XLEN'(4)) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory model plus a
// program-order reference of the instruction stream seen at the F stage.
module tb_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stallF = 1'b0;
  logic        redirectE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        validF;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stallF         (stallF),
    .redirectE      (redirectE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .validF         (validF),
    .instrF         (instrF),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        memq[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  int          pops = 0, gaps = 0;
  logic        drv_stall = 0, drv_redir = 0, drv_ready = 1;
  logic [31:0] drv_target = '0;
  logic [31:0] exp_pc, exp_req;
  logic        s_valid, s_hs, s_rsp, s_reqv;
  logic [31:0] s_pc, s_addr;
  logic        p_valid = 0, p_stall = 0, p_redir = 0;
  logic [31:0] p_pc, p_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // One clock cycle: drive inputs, sample outputs 1ns later, update models.
  task automatic cycle();
    int lat, due;
    stallF         = drv_stall;
    redirectE      = drv_redir;
    PCTargetE      = drv_target;
    imem_req_ready = drv_ready;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    s_valid = validF; s_pc = PCF; s_addr = imem_addr;
    s_rsp = imem_rsp_valid; s_reqv = imem_req_valid;
    s_hs = imem_req_valid & imem_req_ready;

    checks++;
    if (!validF) begin
      if (instrF !== NOP || PCF !== 32'd0 || PCPlus4F !== 32'd0) begin
        errors++;
        $display("FAIL idle_triple cyc=%0d instr=%h pc=%h pc4=%h want %h/0/0", cyc, instrF, PCF, PCPlus4F, NOP);
      end
    end else if (PCPlus4F !== PCF + 32'd4) begin
      errors++;
      $display("FAIL pcplus4 cyc=%0d got %h want %h", cyc, PCPlus4F, PCF + 32'd4);
    end

    if (p_valid && p_stall && !p_redir) begin
      checks++;
      if (validF !== 1'b1 || PCF !== p_pc || instrF !== p_instr) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h", cyc, validF, PCF, instrF, p_pc, p_instr);
      end
    end

    if (redirectE) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_in_redirect cyc=%0d got %b want 0", cyc, imem_req_valid);
      end
    end

    if (s_hs) begin
      checks++;
      if (imem_addr !== exp_req) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got %h want %h", cyc, imem_addr, exp_req);
      end
      exp_req = exp_req + 32'd4;
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: imem_addr, due: due});
    end

    if (validF && !stallF && !redirectE) begin
      checks++;
      if (PCF !== exp_pc || instrF !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL stream cyc=%0d got pc=%h i=%h want pc=%h i=%h", cyc, PCF, instrF, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (!validF) gaps++;

    if (imem_rsp_valid) void'(memq.pop_front());
    if (redirectE) begin
      exp_pc  = {drv_target[31:2], 2'b00};
      exp_req = {drv_target[31:2], 2'b00};
    end
    p_valid = validF; p_stall = stallF; p_redir = redirectE;
    p_pc = PCF; p_instr = instrF;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    cycle();
  endtask

  // One-cycle reset pulse; release is followed immediately by the first cycle.
  task automatic do_reset();
    drv_stall = 0; drv_redir = 0; drv_ready = 1;
    @(negedge clk);
    reset_n = 1'b0;
    imem_rsp_valid = 1'b0; stallF = 1'b0; redirectE = 1'b0; imem_req_ready = 1'b1;
    #1;
    checks++;
    if (validF !== 1'b0 || instrF !== NOP || PCF !== 32'd0 || PCPlus4F !== 32'd0) begin
      errors++;
      $display("FAIL reset_triple got v=%b i=%h pc=%h pc4=%h want 0/%h/0/0", validF, instrF, PCF, PCPlus4F, NOP);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got %b want 0", imem_req_valid);
    end
    @(negedge clk);
    memq.delete();
    last_due = 0;
    exp_pc = RST_PC; exp_req = RST_PC;
    p_valid = 0;
    reset_n = 1'b1;
    cycle();
    checks++;
    if (s_hs !== 1'b1 || s_addr !== RST_PC) begin
      errors++;
      $display("FAIL first_req got hs=%b addr=%h want 1/%h", s_hs, s_addr, RST_PC);
    end
  endtask

  task automatic test_reset_and_stream();
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (k == 1 && s_valid !== 1'b0) begin
        errors++; $display("FAIL first_latency k=1 validF=%b want 0", s_valid);
      end else if (k == 2 && (s_valid !== 1'b1 || s_pc !== RST_PC)) begin
        errors++; $display("FAIL first_valid got v=%b pc=%h want 1/%h", s_valid, s_pc, RST_PC);
      end else if (k > 2 && (s_valid !== 1'b1 || s_hs !== 1'b1)) begin
        errors++; $display("FAIL steady_rate k=%0d got v=%b hs=%b want 1/1", k, s_valid, s_hs);
      end
    end
  endtask

  task automatic test_stall();
    int p0;
    drv_stall = 1;
    for (int s = 0; s < 5; s++) begin
      step();
      if (s >= 3) begin
        checks++;
        if (s_reqv !== 1'b0) begin
          errors++; $display("FAIL credit_stop s=%0d req_valid=%b want 0", s, s_reqv);
        end
      end
    end
    drv_stall = 0;
    p0 = pops;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (pops - p0 != 10) begin
      errors++; $display("FAIL stall_release pops=%0d want 10", pops - p0);
    end
  endtask

  task automatic test_ready_low();
    logic [31:0] a0;
    int p0, g0;
    drv_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) a0 = s_addr;
      checks++;
      if (s_addr !== a0 || s_hs !== 1'b0) begin
        errors++; $display("FAIL addr_hold k=%0d got %h hs=%b want %h/0", k, s_addr, s_hs, a0);
      end
    end
    lat_min = 3; lat_max = 3; drv_ready = 1;
    p0 = pops; g0 = gaps;
    for (int k = 0; k < 25; k++) step();
    checks++;
    if (pops - p0 < 10 || gaps - g0 == 0) begin
      errors++; $display("FAIL slow_mem pops=%0d gaps=%0d want >=10 and >0", pops - p0, gaps - g0);
    end
  endtask

  task automatic test_redirect();
    lat_min = 3; lat_max = 3;
    do_reset();
    step();
    drv_redir = 1; drv_target = 32'h0000_1002;
    step();
    checks++;
    if (s_valid !== 1'b0 || memq.size() != 2) begin
      errors++; $display("FAIL redir_setup v=%b inflight=%0d want 0/2", s_valid, memq.size());
    end
    drv_redir = 0;
    for (int k = 3; k <= 7; k++) begin
      step();
      checks++;
      if (k == 3 && (s_hs !== 1'b1 || s_addr !== 32'h0000_1000)) begin
        errors++; $display("FAIL redir_req got hs=%b addr=%h want 1/00001000", s_hs, s_addr);
      end else if (k > 3 && k < 7 && s_valid !== 1'b0) begin
        errors++; $display("FAIL redir_squash k=%0d validF=%b want 0", k, s_valid);
      end else if (k == 7 && (s_valid !== 1'b1 || s_pc !== 32'h0000_1000)) begin
        errors++; $display("FAIL redir_first got v=%b pc=%h want 1/00001000", s_valid, s_pc);
      end
    end
  endtask

  task automatic test_redirect_timing();
    logic [31:0] tgt;
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 8; k++) step();
    tgt = {16'h0000, 4'h2, 10'($urandom), 2'b00};
    drv_redir = 1; drv_target = tgt | 32'd3;
    step();
    drv_redir = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (k == 1 && (s_valid !== 1'b0 || s_hs !== 1'b1 || s_addr !== tgt)) begin
        errors++; $display("FAIL redir_n1 got v=%b hs=%b addr=%h want 0/1/%h", s_valid, s_hs, s_addr, tgt);
      end else if (k == 2 && s_valid !== 1'b0) begin
        errors++; $display("FAIL redir_n2 validF=%b want 0", s_valid);
      end else if (k == 3 && (s_valid !== 1'b1 || s_pc !== tgt)) begin
        errors++; $display("FAIL redir_n3 got v=%b pc=%h want 1/%h", s_valid, s_pc, tgt);
      end
    end
  endtask

  task automatic test_redirect_rsp_stall();
    for (int k = 0; k < 4; k++) step();
    drv_stall = 1; drv_redir = 1; drv_target = 32'h0000_3000;
    step();
    checks++;
    if (s_rsp !== 1'b1) begin
      errors++; $display("FAIL redir_rsp_same_cycle rsp=%b want 1", s_rsp);
    end
    drv_redir = 0;
    step();
    checks++;
    if (s_valid !== 1'b0) begin
      errors++; $display("FAIL redir_stall_flush validF=%b want 0", s_valid);
    end
    drv_stall = 0;
    step();
    step();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0000_3000) begin
      errors++; $display("FAIL redir_stall_target got v=%b pc=%h want 1/00003000", s_valid, s_pc);
    end
  endtask

  task automatic test_reset_pulse();
    for (int k = 0; k < 5; k++) step();
    do_reset();
    step();
    step();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== RST_PC) begin
      errors++; $display("FAIL restart got v=%b pc=%h want 1/%h", s_valid, s_pc, RST_PC);
    end
  endtask

  task automatic test_random();
    int p0;
    lat_min = 1; lat_max = 4;
    p0 = pops;
    for (int k = 0; k < 2000; k++) begin
      drv_stall  = ($urandom_range(99, 0) < 30);
      drv_ready  = ($urandom_range(99, 0) < 70);
      drv_redir  = ($urandom_range(99, 0) < 3);
      drv_target = $urandom & 32'h0000_FFFF;
      step();
    end
    drv_stall = 0; drv_redir = 0; drv_ready = 1;
    for (int k = 0; k < 20; k++) step();
    checks++;
    if (pops - p0 < 200) begin
      errors++; $display("FAIL random_progress pops=%0d want >=200", pops - p0);
    end
  endtask

  initial begin
    test_reset_and_stream();
    test_stall();
    test_ready_low();
    test_redirect();
    test_redirect_timing();
    test_redirect_rsp_stall();
    test_reset_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Pipelined RV32 instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the PC register and issues in-order requests to a variable-latency instruction memory over a valid/ready port. Returned instructions are buffered, and each is presented with its PC and PC+4 as the F-stage triple (instrF, PCF, PCPlus4F). The unit honours hazard-unit stalls and E-stage branch/jump redirects; wrong-path responses are squashed.

## Interface
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, fetch-buffer entries and total credit limit; power of two, ≥2
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stallF  in  1  hazard-unit stall; head entry held while high
- redirectE  in  1  taken branch/jump resolved in E
- PCTargetE  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  request address
- imem_rsp_valid  in  1  response valid; in order; ≥1 cycle after its handshake
- imem_rsp_data  in  32  instruction word
- validF  out  1  F-stage triple is a real instruction
- instrF  out  32  instruction, or NOP 32'h0000_0013 when validF=0
- PCF  out  XLEN  PC of instrF, 0 when validF=0
- PCPlus4F  out  XLEN  PCF+4, 0 when validF=0

## Operation
- State: pc_q (next request address), rsp_pc_q (PC of the next kept response), outstanding (0..FIFO_DEPTH), drop_cnt (0..outstanding), fetch FIFO of {pc, instr}.
- Request rule: imem_req_valid = ~redirectE & (outstanding + fifo_count < FIFO_DEPTH), using registered counts only. imem_addr = pc_q.
- On handshake: pc_q += 4 (mod 2^XLEN) and outstanding++.
- Response with drop_cnt>0: discarded; drop_cnt-- and outstanding--.
- Response with drop_cnt=0: {rsp_pc_q, imem_rsp_data} pushed; rsp_pc_q += 4; outstanding--.
- Output: head of FIFO drives instrF/PCF; PCPlus4F = PCF+4. Pop when validF & ~stallF.
- Redirect (priority over stall, request and push):
  - pc_q and rsp_pc_q <= {PCTargetE[XLEN-1:2], 2'b00}.
  - FIFO flushed.
  - drop_cnt <= outstanding minus any response arriving that cycle (that response is discarded).
  - No request is issued in the redirect cycle.
- Simultaneous handshake and response: outstanding unchanged.
- The FIFO cannot overflow by construction: credits include outstanding requests. Overflow is an assertion failure.
- Reset (any time, async):
  - pc_q = rsp_pc_q = RESET_PC; outstanding = drop_cnt = 0; FIFO empty.
  - Outputs: validF=0, instrF=NOP, PCF=PCPlus4F=0, imem_req_valid=0 while reset_n low.
  - Memory responses still in flight at reset are the memory's responsibility (memory is reset too).

## Timing
- First request in the first cycle after reset_n rises.
- Latency: a response accepted in cycle n is visible on validF/instrF in cycle n+1 (registered FIFO, no bypass).
- With 1-cycle memory and FIFO_DEPTH=4: steady state one instruction per cycle.
- Redirect in cycle n:
  - target request in cycle n+1;
  - first target instruction on validF at n+3 with 1-cycle memory;
  - validF=0 in cycle n+1.
- stallF does not block requests; fetch continues until credits run out.

## Structure
- fetch_pkg: NOP_INSTR constant, fetch_entry_t struct {pc, instr}, clog2-based count widths.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush and count; async active-low reset. Parameterised by FIFO_DEPTH.
- Credit/drop counters and the PC registers stay in fetch_unit.

## Test plan
- Reset release, 1-cycle memory always ready: requests at 0x0, 0x4, 0x8…; PCF 0x0 appears 2 cycles after the first request; then one instruction per cycle, PCPlus4F=PCF+4.
- stallF held 5 cycles mid-stream: triple frozen; requests stop after 4 credits; no loss or duplication after release.
- imem_req_ready low 3 cycles, then 3-cycle response latency: imem_addr stable while unaccepted; order preserved; validF gaps but correct PCs.
- redirectE to 0x1002 with 2 requests outstanding: both responses discarded, FIFO emptied; next request 0x1000; next validF shows PCF=0x1000.
- Redirect in the same cycle as a response and stallF=1: response dropped, redirect wins, stall ignored for flush; next valid PCF = target.
- reset_n pulsed low mid-stream for one cycle: validF=0 immediately; restart at RESET_PC with counters zero.
